// File: rtl/udp_tx_sched.sv
`timescale 1ns/1ps
// Transmit scheduler for the single UDP tx channel: round-robin arbitration between
// the data FIFO and the command-reply FIFO, MAC handshake, and length-exact byte streaming.
module udp_tx_sched #(
  parameter logic [11:0] MAX_LEN  = 12'd1472,
  parameter logic [15:0] TOUT_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs_data,
  input  logic [11:0] data_len,
  output logic        fd_data,
  output logic        fifod_rxen,
  input  logic [7:0]  fifod_rxd,
  input  logic        fs_cmd,
  input  logic [11:0] cmd_len,
  output logic        fd_cmd,
  output logic        fifoc_rxen,
  input  logic [7:0]  fifoc_rxd,
  input  logic        flag_udp_tx_prep,
  output logic        fs_udp_tx,
  output logic [11:0] udp_tx_len,
  input  logic        flag_udp_tx_req,
  output logic        udp_txen,
  output logic [7:0]  udp_txd,
  input  logic        fd_udp_tx,
  output logic        busy,
  output logic        err_len,
  output logic        err_tout
);

  typedef enum logic [2:0] {IDLE, CHECK, START, READ, WAIT_DONE, DONE, ERR} state_t;

  state_t      state;
  logic        grant_cmd;
  logic        ptr_cmd;
  logic        armed_data;
  logic        armed_cmd;
  logic [11:0] len_r;
  logic [11:0] byte_cnt;
  logic [15:0] tout_cnt;

  logic pend_data;
  logic pend_cmd;
  logic pick_cmd;
  logic tout_hit;

  // A held fs must be released before its channel can be granted again.
  assign pend_data = fs_data & armed_data;
  assign pend_cmd  = fs_cmd & armed_cmd;
  assign pick_cmd  = pend_cmd & (~pend_data | ptr_cmd);
  assign tout_hit  = (tout_cnt == TOUT_CYC - 16'd1);

  assign udp_txd = udp_txen ? (grant_cmd ? fifoc_rxd : fifod_rxd) : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_cmd  <= 1'b0;
      ptr_cmd    <= 1'b1;
      armed_data <= 1'b1;
      armed_cmd  <= 1'b1;
      len_r      <= 12'd0;
      byte_cnt   <= 12'd0;
      tout_cnt   <= 16'd0;
      fd_data    <= 1'b0;
      fd_cmd     <= 1'b0;
      fifod_rxen <= 1'b0;
      fifoc_rxen <= 1'b0;
      fs_udp_tx  <= 1'b0;
      udp_tx_len <= 12'd0;
      udp_txen   <= 1'b0;
      busy       <= 1'b0;
      err_len    <= 1'b0;
      err_tout   <= 1'b0;
    end else begin
      fd_data  <= 1'b0;
      fd_cmd   <= 1'b0;
      err_len  <= 1'b0;
      err_tout <= 1'b0;
      udp_txen <= fifod_rxen | fifoc_rxen;

      if (fd_data)      armed_data <= 1'b0;
      else if (!fs_data) armed_data <= 1'b1;
      if (fd_cmd)       armed_cmd <= 1'b0;
      else if (!fs_cmd) armed_cmd <= 1'b1;

      case (state)
        IDLE: begin
          tout_cnt <= 16'd0;
          byte_cnt <= 12'd0;
          if ((pend_data | pend_cmd) && flag_udp_tx_prep) begin
            grant_cmd <= pick_cmd;
            len_r     <= pick_cmd ? cmd_len : data_len;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (len_r == 12'd0 || len_r > MAX_LEN) begin
            err_len <= 1'b1;
            fd_cmd  <= grant_cmd;
            fd_data <= ~grant_cmd;
            state   <= ERR;
          end else begin
            fs_udp_tx  <= 1'b1;
            udp_tx_len <= len_r;
            state      <= START;
          end
        end
        START: begin
          if (flag_udp_tx_req) begin
            tout_cnt   <= 16'd0;
            fifod_rxen <= ~grant_cmd;
            fifoc_rxen <= grant_cmd;
            state      <= READ;
          end else if (tout_hit) begin
            err_tout   <= 1'b1;
            fd_cmd     <= grant_cmd;
            fd_data    <= ~grant_cmd;
            fs_udp_tx  <= 1'b0;
            udp_tx_len <= 12'd0;
            state      <= ERR;
          end else begin
            tout_cnt <= tout_cnt + 16'd1;
          end
        end
        READ: begin
          if (byte_cnt == len_r - 12'd1) begin
            fifod_rxen <= 1'b0;
            fifoc_rxen <= 1'b0;
            state      <= WAIT_DONE;
          end else begin
            byte_cnt <= byte_cnt + 12'd1;
          end
        end
        // A timeout here still counts the burst as consumed from the FIFO.
        WAIT_DONE: begin
          if (fd_udp_tx) begin
            fd_cmd     <= grant_cmd;
            fd_data    <= ~grant_cmd;
            fs_udp_tx  <= 1'b0;
            udp_tx_len <= 12'd0;
            state      <= DONE;
          end else if (tout_hit) begin
            err_tout   <= 1'b1;
            fd_cmd     <= grant_cmd;
            fd_data    <= ~grant_cmd;
            fs_udp_tx  <= 1'b0;
            udp_tx_len <= 12'd0;
            state      <= ERR;
          end else begin
            tout_cnt <= tout_cnt + 16'd1;
          end
        end
        DONE, ERR: begin
          ptr_cmd <= ~ptr_cmd;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
`timescale 1ns/1ps
// Directed self-checking bench for udp_tx_sched with behavioural FIFO and MAC responders.
module tb_udp_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs_data = 1'b0;
  logic [11:0] data_len = 12'd0;
  logic        fd_data;
  logic        fifod_rxen;
  logic [7:0]  fifod_rxd = 8'd0;
  logic        fs_cmd = 1'b0;
  logic [11:0] cmd_len = 12'd0;
  logic        fd_cmd;
  logic        fifoc_rxen;
  logic [7:0]  fifoc_rxd = 8'd0;
  logic        flag_udp_tx_prep = 1'b1;
  logic        fs_udp_tx;
  logic [11:0] udp_tx_len;
  logic        flag_udp_tx_req = 1'b0;
  logic        udp_txen;
  logic [7:0]  udp_txd;
  logic        fd_udp_tx = 1'b0;
  logic        busy;
  logic        err_len;
  logic        err_tout;

  udp_tx_sched #(.MAX_LEN(12'd1472), .TOUT_CYC(16'd16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fs_data(fs_data), .data_len(data_len), .fd_data(fd_data),
    .fifod_rxen(fifod_rxen), .fifod_rxd(fifod_rxd),
    .fs_cmd(fs_cmd), .cmd_len(cmd_len), .fd_cmd(fd_cmd),
    .fifoc_rxen(fifoc_rxen), .fifoc_rxd(fifoc_rxd),
    .flag_udp_tx_prep(flag_udp_tx_prep), .fs_udp_tx(fs_udp_tx), .udp_tx_len(udp_tx_len),
    .flag_udp_tx_req(flag_udp_tx_req), .udp_txen(udp_txen), .udp_txd(udp_txd),
    .fd_udp_tx(fd_udp_tx), .busy(busy), .err_len(err_len), .err_tout(err_tout)
  );

  always #5 clk = ~clk;

  // FIFO models: one-cycle read latency, contents preloaded by the stimulus.
  logic [7:0]  dmem [4096];
  logic [7:0]  cmem [4096];
  logic [11:0] d_rd = 12'd0;
  logic [11:0] c_rd = 12'd0;

  always @(posedge clk) begin
    if (fifod_rxen) begin
      fifod_rxd <= dmem[d_rd];
      d_rd      <= d_rd + 12'd1;
    end
    if (fifoc_rxen) begin
      fifoc_rxd <= cmem[c_rd];
      c_rd      <= c_rd + 12'd1;
    end
  end

  // MAC model: req after req_delay cycles of fs_udp_tx (0 = never), fd once the burst ends.
  int   req_delay = 3;
  bit   fd_en = 1'b1;
  bit   fd_early = 1'b0;
  int   mac_cnt = 0;
  bit   req_done = 1'b0;
  bit   seen_txen = 1'b0;
  bit   fd_sent = 1'b0;

  always @(negedge clk) begin
    if (!fs_udp_tx) begin
      mac_cnt         <= 0;
      req_done        <= 1'b0;
      seen_txen       <= 1'b0;
      fd_sent         <= 1'b0;
      flag_udp_tx_req <= 1'b0;
      fd_udp_tx       <= 1'b0;
    end else begin
      mac_cnt <= mac_cnt + 1;
      if (!req_done && req_delay > 0 && mac_cnt + 1 == req_delay) begin
        flag_udp_tx_req <= 1'b1;
        req_done        <= 1'b1;
      end else begin
        flag_udp_tx_req <= 1'b0;
      end
      if (udp_txen) seen_txen <= 1'b1;
      if (fd_early && !(seen_txen && !udp_txen)) begin
        fd_udp_tx <= 1'b1;
      end else if (fd_en && seen_txen && !udp_txen && !fd_sent) begin
        fd_udp_tx <= 1'b1;
        fd_sent   <= 1'b1;
      end else begin
        fd_udp_tx <= 1'b0;
      end
    end
  end

  // Output monitor: event counters and captured payload bytes.
  int         cnt_rxd = 0, cnt_rxc = 0, cnt_rxr = 0, cnt_tx = 0, cnt_txr = 0;
  int         cnt_fdd = 0, cnt_fdc = 0, cnt_fda = 0, cnt_el = 0, cnt_et = 0;
  int         cnt_fs = 0, cnt_len_bad = 0;
  logic [11:0] last_len = 12'd0;
  logic [7:0] rx_byte [8192];
  logic       grant_seq [64];
  bit         prev_rxen = 1'b0, prev_txen = 1'b0, prev_tout = 1'b0;
  logic       busy_after_tout = 1'b1;

  always @(negedge clk) begin
    if (fifod_rxen) cnt_rxd <= cnt_rxd + 1;
    if (fifoc_rxen) cnt_rxc <= cnt_rxc + 1;
    if ((fifod_rxen | fifoc_rxen) && !prev_rxen) cnt_rxr <= cnt_rxr + 1;
    prev_rxen <= fifod_rxen | fifoc_rxen;
    if (udp_txen) begin
      rx_byte[cnt_tx % 8192] <= udp_txd;
      cnt_tx <= cnt_tx + 1;
      if (!prev_txen) cnt_txr <= cnt_txr + 1;
    end
    prev_txen <= udp_txen;
    if (fd_data) begin
      cnt_fdd <= cnt_fdd + 1;
      grant_seq[cnt_fda % 64] <= 1'b0;
      cnt_fda <= cnt_fda + 1;
    end
    if (fd_cmd) begin
      cnt_fdc <= cnt_fdc + 1;
      grant_seq[cnt_fda % 64] <= 1'b1;
      cnt_fda <= cnt_fda + 1;
    end
    if (err_len)  cnt_el <= cnt_el + 1;
    if (err_tout) cnt_et <= cnt_et + 1;
    if (fs_udp_tx) begin
      cnt_fs   <= cnt_fs + 1;
      last_len <= udp_tx_len;
    end else if (udp_tx_len != 12'd0) begin
      cnt_len_bad <= cnt_len_bad + 1;
    end
    if (prev_tout) busy_after_tout <= busy;
    prev_tout <= err_tout;
  end

  int checks = 0;
  int failures = 0;
  int b_rxd, b_rxc, b_rxr, b_tx, b_txr, b_fdd, b_fdc, b_fda, b_el, b_et, b_fs;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rxd = cnt_rxd; b_rxc = cnt_rxc; b_rxr = cnt_rxr; b_tx = cnt_tx; b_txr = cnt_txr;
    b_fdd = cnt_fdd; b_fdc = cnt_fdc; b_fda = cnt_fda; b_el = cnt_el; b_et = cnt_et;
    b_fs = cnt_fs;
  endtask

  task automatic wait_fds(input int n, input int budget, input string tag);
    int target;
    bit hit;
    target = cnt_fdd + cnt_fdc + n;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (cnt_fdd + cnt_fdc >= target) hit = 1'b1;
    end
    tick();
    tick();
    check_output({tag, "_done"}, 32'(hit), 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    fs_data = 1'b0;
    fs_cmd = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({busy, fs_udp_tx, udp_txen, fd_data, fd_cmd, fifod_rxen, fifoc_rxen,
                err_len, err_tout, udp_tx_len, udp_txd});
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] bad_lens [2];
    int  bad;
    bit  hit;

    // Reset state
    repeat (3) tick();
    check_output("reset_outputs", out_vec(), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check_output("reset_idle", out_vec(), 32'd0);

    // Single data frame of 4 bytes
    snap();
    for (int i = 0; i < 4; i++) dmem[d_rd + 12'(i)] = 8'hA0 + 8'(i);
    data_len = 12'd4;
    fs_data = 1'b1;
    wait_fds(1, 100, "t1");
    fs_data = 1'b0;
    tick();
    check_output("t1_tx_len", 32'(last_len), 32'd4);
    check_output("t1_fifod_rxen", 32'(cnt_rxd - b_rxd), 32'd4);
    check_output("t1_fifod_runs", 32'(cnt_rxr - b_rxr), 32'd1);
    check_output("t1_fifoc_rxen", 32'(cnt_rxc - b_rxc), 32'd0);
    check_output("t1_txen", 32'(cnt_tx - b_tx), 32'd4);
    check_output("t1_txen_runs", 32'(cnt_txr - b_txr), 32'd1);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("t1_byte%0d", i), 32'(rx_byte[(b_tx + i) % 8192]), 32'(8'hA0 + i));
    check_output("t1_fd_data", 32'(cnt_fdd - b_fdd), 32'd1);
    check_output("t1_fd_cmd", 32'(cnt_fdc - b_fdc), 32'd0);

    // Both requesters at once after reset, fs held past fd
    apply_reset();
    snap();
    dmem[d_rd] = 8'hD0; dmem[d_rd + 12'd1] = 8'hD1;
    cmem[c_rd] = 8'hC0; cmem[c_rd + 12'd1] = 8'hC1;
    data_len = 12'd2;
    cmd_len = 12'd2;
    fs_data = 1'b1;
    fs_cmd = 1'b1;
    wait_fds(2, 200, "t2");
    repeat (10) tick();
    fs_data = 1'b0;
    fs_cmd = 1'b0;
    repeat (2) tick();
    check_output("t2_first_is_cmd", 32'(grant_seq[b_fda % 64]), 32'd1);
    check_output("t2_second_is_data", 32'(grant_seq[(b_fda + 1) % 64]), 32'd0);
    check_output("t2_fd_cmd_once", 32'(cnt_fdc - b_fdc), 32'd1);
    check_output("t2_fd_data_once", 32'(cnt_fdd - b_fdd), 32'd1);
    check_output("t2_byte0", 32'(rx_byte[b_tx % 8192]), 32'hC0);
    check_output("t2_byte1", 32'(rx_byte[(b_tx + 1) % 8192]), 32'hC1);
    check_output("t2_byte2", 32'(rx_byte[(b_tx + 2) % 8192]), 32'hD0);
    check_output("t2_byte3", 32'(rx_byte[(b_tx + 3) % 8192]), 32'hD1);

    // Illegal lengths on the command channel
    bad_lens[0] = 12'd0;
    bad_lens[1] = 12'd1473;
    for (int k = 0; k < 2; k++) begin
      snap();
      cmd_len = bad_lens[k];
      fs_cmd = 1'b1;
      wait_fds(1, 20, $sformatf("t3_len%0d", bad_lens[k]));
      fs_cmd = 1'b0;
      tick();
      check_output($sformatf("t3_err_len_%0d", bad_lens[k]), 32'(cnt_el - b_el), 32'd1);
      check_output($sformatf("t3_fd_cmd_%0d", bad_lens[k]), 32'(cnt_fdc - b_fdc), 32'd1);
      check_output($sformatf("t3_fs_udp_%0d", bad_lens[k]), 32'(cnt_fs - b_fs), 32'd0);
      check_output($sformatf("t3_rxen_%0d", bad_lens[k]), 32'(cnt_rxd - b_rxd + cnt_rxc - b_rxc), 32'd0);
    end

    // MAC never raises req: START timeout
    snap();
    req_delay = 0;
    data_len = 12'd4;
    fs_data = 1'b1;
    wait_fds(1, 100, "t4");
    fs_data = 1'b0;
    tick();
    check_output("t4_fs_cycles", 32'(cnt_fs - b_fs), 32'd16);
    check_output("t4_err_tout", 32'(cnt_et - b_et), 32'd1);
    check_output("t4_fd_data", 32'(cnt_fdd - b_fdd), 32'd1);
    check_output("t4_no_rxen", 32'(cnt_rxd - b_rxd), 32'd0);
    check_output("t4_busy_after", 32'(busy_after_tout), 32'd0);
    req_delay = 3;

    // MAC never raises fd: WAIT_DONE timeout after bytes consumed
    snap();
    fd_en = 1'b0;
    dmem[d_rd] = 8'h11; dmem[d_rd + 12'd1] = 8'h22;
    data_len = 12'd2;
    fs_data = 1'b1;
    wait_fds(1, 100, "t5");
    fs_data = 1'b0;
    tick();
    check_output("t5_err_tout", 32'(cnt_et - b_et), 32'd1);
    check_output("t5_txen", 32'(cnt_tx - b_tx), 32'd2);
    check_output("t5_fs_cycles", 32'(cnt_fs - b_fs), 32'd21);
    check_output("t5_fd_data", 32'(cnt_fdd - b_fdd), 32'd1);
    fd_en = 1'b1;

    // fs dropped mid-transfer, fd_udp_tx held early during START/READ
    snap();
    fd_early = 1'b1;
    for (int i = 0; i < 3; i++) dmem[d_rd + 12'(i)] = 8'h31 + 8'(i);
    data_len = 12'd3;
    fs_data = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (cnt_rxd - b_rxd >= 1) hit = 1'b1;
    end
    check_output("t6_read_started", 32'(hit), 32'd1);
    fs_data = 1'b0;
    wait_fds(1, 100, "t6");
    fd_early = 1'b0;
    check_output("t6_txen", 32'(cnt_tx - b_tx), 32'd3);
    check_output("t6_last_byte", 32'(rx_byte[(b_tx + 2) % 8192]), 32'h33);
    check_output("t6_fd_data", 32'(cnt_fdd - b_fdd), 32'd1);

    // Request waits while the MAC is not prepared
    snap();
    flag_udp_tx_prep = 1'b0;
    cmem[c_rd] = 8'h77;
    cmd_len = 12'd1;
    fs_cmd = 1'b1;
    repeat (30) tick();
    check_output("t7_wait_busy", 32'(busy), 32'd0);
    check_output("t7_wait_fd", 32'(cnt_fdc - b_fdc), 32'd0);
    flag_udp_tx_prep = 1'b1;
    wait_fds(1, 100, "t7");
    fs_cmd = 1'b0;
    tick();
    check_output("t7_byte", 32'(rx_byte[b_tx % 8192]), 32'h77);
    check_output("t7_fd_cmd", 32'(cnt_fdc - b_fdc), 32'd1);

    // Largest legal frame
    snap();
    for (int i = 0; i < 1472; i++) dmem[d_rd + 12'(i)] = 8'((i * 7 + 3) & 255);
    data_len = 12'd1472;
    fs_data = 1'b1;
    wait_fds(1, 3000, "t8");
    fs_data = 1'b0;
    tick();
    check_output("t8_tx_len", 32'(last_len), 32'd1472);
    check_output("t8_txen", 32'(cnt_tx - b_tx), 32'd1472);
    check_output("t8_txen_runs", 32'(cnt_txr - b_txr), 32'd1);
    check_output("t8_rxen", 32'(cnt_rxd - b_rxd), 32'd1472);
    bad = 0;
    for (int i = 0; i < 1472; i++)
      if (rx_byte[(b_tx + i) % 8192] !== 8'((i * 7 + 3) & 255)) bad++;
    check_output("t8_bytes_bad", 32'(bad), 32'd0);
    check_output("t8_no_err", 32'(cnt_el - b_el + cnt_et - b_et), 32'd0);

    // Asynchronous reset mid-burst, then a normal 1-byte frame
    snap();
    for (int i = 0; i < 8; i++) dmem[d_rd + 12'(i)] = 8'h80 + 8'(i);
    data_len = 12'd8;
    fs_data = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      if (cnt_rxd - b_rxd >= 3) hit = 1'b1;
    end
    check_output("t9_reached_byte3", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t9_async_clear", out_vec(), 32'd0);
    fs_data = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    snap();
    dmem[d_rd] = 8'h5A;
    data_len = 12'd1;
    fs_data = 1'b1;
    wait_fds(1, 100, "t9");
    fs_data = 1'b0;
    tick();
    check_output("t9_txen", 32'(cnt_tx - b_tx), 32'd1);
    check_output("t9_byte", 32'(rx_byte[b_tx % 8192]), 32'h5A);
    check_output("t9_fd_data", 32'(cnt_fdd - b_fdd), 32'd1);

    check_output("len_zero_outside_frame", 32'(cnt_len_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
